// File: rtl/ysyx_25040129_imem_rsp_pkg.sv
// Shared definitions for the instruction-memory read responder: bus widths,
// response codes, reset vector, FSM states and the response payload struct.
package ysyx_25040129_imem_rsp_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned AW33    = XLEN + 1;
  localparam int unsigned RESP_W  = 2;
  localparam int unsigned CNT_W   = 4;

  typedef logic [XLEN-1:0] word_t;

  localparam word_t START_ADDR = 32'h8000_0000;

  localparam logic [RESP_W-1:0] OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] SLVERR = 2'b10;
  localparam logic [RESP_W-1:0] DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    RESP  = 2'd2
  } state_e;

  typedef struct packed {
    word_t             data;
    logic [RESP_W-1:0] resp;
  } rsp_t;

  // Classify a read address; misalignment wins over an out-of-range address.
  // Range compare runs one bit wider so base+span can never wrap to a hit.
  function automatic logic [RESP_W-1:0] decode_resp(
    input word_t           addr,
    input word_t           base,
    input logic [AW33-1:0] span_bytes
  );
    logic [AW33-1:0] a33;
    logic [AW33-1:0] lo33;
    logic [AW33-1:0] hi33;
    a33  = {1'b0, addr};
    lo33 = {1'b0, base};
    hi33 = lo33 + span_bytes;
    if (addr[1:0] != 2'b00) begin
      return SLVERR;
    end
    if ((a33 < lo33) || (a33 >= hi33)) begin
      return DECERR;
    end
    return OKAY;
  endfunction

endpackage

// File: rtl/ysyx_25040129_imem_rsp_sram_1r1w.sv
// Word-wide storage with a synchronous write port and an asynchronous read
// port; the parent samples the read port on the AR handshake edge, so a
// write landing on that same edge is not visible in the captured word.
module ysyx_25040129_sram_1r1w
  import ysyx_25040129_imem_rsp_pkg::*;
#(
  parameter  int unsigned DEPTH_WORDS = 4096,
  localparam int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_widx,
  input  word_t            i_wdata,
  input  logic [IDX_W-1:0] i_ridx,
  output word_t            o_rdata_c
);

  word_t r_mem [DEPTH_WORDS];

  // Write port: contents are never cleared, not even by reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_widx] <= i_wdata;
    end
  end

  assign o_rdata_c = r_mem[i_ridx];

endmodule

// File: rtl/ysyx_25040129_imem_rsp.sv
// Single-outstanding AXI-lite-style read responder in front of a preloadable
// instruction memory, with a programmable AR-to-R latency.
module ysyx_25040129_imem_rsp
  import ysyx_25040129_imem_rsp_pkg::*;
#(
  parameter  word_t       BASE_ADDR   = START_ADDR,
  parameter  int unsigned DEPTH_WORDS = 4096,
  parameter  int unsigned LATENCY     = 2,
  localparam int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      araddr,
  input  logic             arvalid,
  output logic             arready,
  output logic [31:0]      rdata,
  output logic [1:0]       rresp,
  output logic             rvalid,
  input  logic             rready,
  input  logic             ld_en,
  input  logic [IDX_W-1:0] ld_idx,
  input  logic [31:0]      ld_data
);

  localparam logic [AW33-1:0] SPAN_BYTES = AW33'(DEPTH_WORDS) << 2;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  rsp_t              r_rsp;
  logic              w_hs;
  logic [RESP_W-1:0] w_resp;
  logic [IDX_W-1:0]  w_ridx;
  word_t             w_mem_rdata;

  assign w_resp = decode_resp(araddr, BASE_ADDR, SPAN_BYTES);
  assign w_ridx = IDX_W'((araddr - BASE_ADDR) >> 2);

  ysyx_25040129_sram_1r1w #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_sram (
    .clk       (clk),
    .i_we      (ld_en),
    .i_widx    (ld_idx),
    .i_wdata   (ld_data),
    .i_ridx    (w_ridx),
    .o_rdata_c (w_mem_rdata)
  );

  // Next-state and AR handshake decode.
  always_comb begin
    w_state_nxt = r_state;
    w_hs        = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (arvalid) begin
          w_hs        = 1'b1;
          w_state_nxt = (LATENCY == 0) ? RESP : DELAY;
        end
      end
      DELAY: begin
        if (r_cnt <= CNT_W'(1)) begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        if (rready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register; reset drops any in-flight read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Latency counter: loaded at handshake, counts down through DELAY.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_hs) begin
      r_cnt <= CNT_W'(LATENCY);
    end else if (r_state == DELAY) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Response payload captured once at handshake and held until consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp <= '0;
    end else if (w_hs) begin
      r_rsp.resp <= w_resp;
      r_rsp.data <= (w_resp == OKAY) ? w_mem_rdata : '0;
    end
  end

  assign arready = (r_state == IDLE);
  assign rvalid  = (r_state == RESP);
  assign rdata   = r_rsp.data;
  assign rresp   = r_rsp.resp;

endmodule

// File: tb/tb_ysyx_25040129_imem_rsp.sv
// Directed bench: instance A runs LATENCY=2, instance B runs LATENCY=0.
module tb_ysyx_25040129_imem_rsp;

  logic        clk;
  logic        rst;
  logic        ld_en;
  logic [11:0] ld_idx;
  logic [31:0] ld_data;

  logic [31:0] araddr_a, rdata_a;
  logic        arvalid_a, arready_a, rvalid_a, rready_a;
  logic [1:0]  rresp_a;

  logic [31:0] araddr_b, rdata_b;
  logic        arvalid_b, arready_b, rvalid_b, rready_b;
  logic [1:0]  rresp_b;

  int n_cmp;
  int n_fail;

  ysyx_25040129_imem_rsp #(.BASE_ADDR(32'h8000_0000), .DEPTH_WORDS(4096), .LATENCY(2)) u_dut_a (
    .clk(clk), .rst(rst), .araddr(araddr_a), .arvalid(arvalid_a), .arready(arready_a),
    .rdata(rdata_a), .rresp(rresp_a), .rvalid(rvalid_a), .rready(rready_a),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data)
  );

  ysyx_25040129_imem_rsp #(.BASE_ADDR(32'h8000_0000), .DEPTH_WORDS(4096), .LATENCY(0)) u_dut_b (
    .clk(clk), .rst(rst), .araddr(araddr_b), .arvalid(arvalid_b), .arready(arready_b),
    .rdata(rdata_b), .rresp(rresp_b), .rvalid(rvalid_b), .rready(rready_b),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one read on A; returns cycles from handshake edge to rvalid (-1 on timeout).
  task automatic read_a(input logic [31:0] addr, input logic do_ld, input logic [11:0] idx,
                        input logic [31:0] d, output int lat, output logic [31:0] data,
                        output logic [1:0] resp);
    @(negedge clk);
    araddr_a = addr; arvalid_a = 1'b1; rready_a = 1'b1;
    if (do_ld) begin ld_en = 1'b1; ld_idx = idx; ld_data = d; end
    @(negedge clk);
    arvalid_a = 1'b0; ld_en = 1'b0;
    lat = -1; data = '0; resp = '0;
    for (int c = 1; c <= 40; c++) begin
      if (rvalid_a) begin lat = c; data = rdata_a; resp = rresp_a; break; end
      @(negedge clk);
    end
    if (lat > 0) @(negedge clk);
    rready_a = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] idxs [6] = '{12'd0, 12'd1, 12'd2, 12'd3, 12'd5, 12'd4095};
    logic [31:0] vals [6] = '{32'h0000_0413, 32'hCAFE_F00D, 32'h2222_2222,
                              32'h3333_3333, 32'h1111_1111, 32'h1234_5678};
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ld_en = 1'b1; ld_idx = idxs[i]; ld_data = vals[i];
    end
    @(negedge clk);
    ld_en = 1'b0;
    @(negedge clk);
    n_cmp++; if (arready_a !== 1'b1) begin n_fail++; $display("FAIL reset_arready_a got %b want 1", arready_a); end
    n_cmp++; if (rvalid_a !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid_a got %b want 0", rvalid_a); end
    n_cmp++; if (rdata_a !== 32'h0) begin n_fail++; $display("FAIL reset_rdata_a got %h want 0", rdata_a); end
    n_cmp++; if (rresp_a !== 2'b00) begin n_fail++; $display("FAIL reset_rresp_a got %b want 00", rresp_a); end
    n_cmp++; if (arready_b !== 1'b1) begin n_fail++; $display("FAIL reset_arready_b got %b want 1", arready_b); end
    n_cmp++; if (rvalid_b !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid_b got %b want 0", rvalid_b); end
    rst = 1'b0;
  endtask

  task automatic test_latency();
    int lat; logic [31:0] d; logic [1:0] r;
    read_a(32'h8000_0000, 1'b0, 12'd0, 32'h0, lat, d, r);
    n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL latency got %0d want 3", lat); end
    n_cmp++; if (d !== 32'h0000_0413) begin n_fail++; $display("FAIL latency_data got %h want 00000413", d); end
    n_cmp++; if (r !== 2'b00) begin n_fail++; $display("FAIL latency_resp got %b want 00", r); end
  endtask

  task automatic test_errors();
    logic [31:0] addrs [6] = '{32'h8000_0002, 32'h7FFF_FFFC, 32'h8000_4000,
                               32'h8000_4001, 32'hFFFF_FFFC, 32'h8000_3FFC};
    logic [1:0]  resps [6] = '{2'b10, 2'b11, 2'b11, 2'b10, 2'b11, 2'b00};
    logic [31:0] datas [6] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1234_5678};
    int lat; logic [31:0] d; logic [1:0] r;
    for (int i = 0; i < 6; i++) begin
      read_a(addrs[i], 1'b0, 12'd0, 32'h0, lat, d, r);
      n_cmp++; if (r !== resps[i]) begin n_fail++; $display("FAIL err_resp[%h] got %b want %b", addrs[i], r, resps[i]); end
      n_cmp++; if (d !== datas[i]) begin n_fail++; $display("FAIL err_data[%h] got %h want %h", addrs[i], d, datas[i]); end
      n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL err_lat[%h] got %0d want 3", addrs[i], lat); end
    end
  endtask

  task automatic test_stall();
    int waited;
    @(negedge clk);
    araddr_a = 32'h8000_0004; arvalid_a = 1'b1; rready_a = 1'b0;
    @(negedge clk);
    araddr_a = 32'h8000_0002;
    waited = 0;
    while (!rvalid_a && waited < 40) begin @(negedge clk); waited++; end
    n_cmp++; if (rvalid_a !== 1'b1) begin n_fail++; $display("FAIL stall_reach_resp got %b want 1", rvalid_a); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (rvalid_a !== 1'b1) begin n_fail++; $display("FAIL stall_rvalid[%0d] got %b want 1", i, rvalid_a); end
      n_cmp++; if (rdata_a !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL stall_rdata[%0d] got %h want cafef00d", i, rdata_a); end
      n_cmp++; if (rresp_a !== 2'b00) begin n_fail++; $display("FAIL stall_rresp[%0d] got %b want 00", i, rresp_a); end
      n_cmp++; if (arready_a !== 1'b0) begin n_fail++; $display("FAIL stall_arready[%0d] got %b want 0", i, arready_a); end
      @(negedge clk);
    end
    arvalid_a = 1'b0; rready_a = 1'b1;
    @(negedge clk);
    n_cmp++; if (rvalid_a !== 1'b0) begin n_fail++; $display("FAIL stall_single_beat got %b want 0", rvalid_a); end
    n_cmp++; if (arready_a !== 1'b1) begin n_fail++; $display("FAIL stall_back_idle got %b want 1", arready_a); end
    rready_a = 1'b0;
    @(negedge clk);
    n_cmp++; if (rvalid_a !== 1'b0) begin n_fail++; $display("FAIL stall_no_extra got %b want 0", rvalid_a); end
  endtask

  task automatic test_read_before_write();
    int lat; logic [31:0] d; logic [1:0] r;
    read_a(32'h8000_0014, 1'b1, 12'd5, 32'hDEAD_BEEF, lat, d, r);
    n_cmp++; if (d !== 32'h1111_1111) begin n_fail++; $display("FAIL rbw_old got %h want 11111111", d); end
    n_cmp++; if (r !== 2'b00) begin n_fail++; $display("FAIL rbw_resp got %b want 00", r); end
    read_a(32'h8000_0014, 1'b0, 12'd0, 32'h0, lat, d, r);
    n_cmp++; if (d !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rbw_new got %h want deadbeef", d); end
  endtask

  task automatic test_reset_in_delay();
    logic seen;
    int lat; logic [31:0] d; logic [1:0] r;
    @(negedge clk);
    araddr_a = 32'h8000_0000; arvalid_a = 1'b1; rready_a = 1'b1;
    @(negedge clk);
    arvalid_a = 1'b0;
    n_cmp++; if (rvalid_a !== 1'b0) begin n_fail++; $display("FAIL rstdly_in_delay got %b want 0", rvalid_a); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (arready_a !== 1'b1) begin n_fail++; $display("FAIL rstdly_arready got %b want 1", arready_a); end
    n_cmp++; if (rvalid_a !== 1'b0) begin n_fail++; $display("FAIL rstdly_rvalid got %b want 0", rvalid_a); end
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rvalid_a) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rstdly_ghost_beat got %b want 0", seen); end
    rready_a = 1'b0;
    read_a(32'h8000_0000, 1'b0, 12'd0, 32'h0, lat, d, r);
    n_cmp++; if (d !== 32'h0000_0413) begin n_fail++; $display("FAIL rstdly_mem_kept got %h want 00000413", d); end
    n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL rstdly_lat got %0d want 3", lat); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [4] = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008, 32'h8000_000C};
    logic [31:0] exps  [4] = '{32'h0000_0413, 32'hCAFE_F00D, 32'h2222_2222, 32'h3333_3333};
    @(negedge clk);
    araddr_b = addrs[0]; arvalid_b = 1'b1; rready_b = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++; if (rvalid_b !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d] got %b want 1", k, rvalid_b); end
      n_cmp++; if (rdata_b !== exps[k]) begin n_fail++; $display("FAIL b2b_data[%0d] got %h want %h", k, rdata_b, exps[k]); end
      n_cmp++; if (rresp_b !== 2'b00) begin n_fail++; $display("FAIL b2b_resp[%0d] got %b want 00", k, rresp_b); end
      if (k < 3) araddr_b = addrs[k+1];
      else arvalid_b = 1'b0;
      @(negedge clk);
      n_cmp++; if (rvalid_b !== 1'b0) begin n_fail++; $display("FAIL b2b_gap[%0d] got %b want 0", k, rvalid_b); end
      n_cmp++; if (arready_b !== 1'b1) begin n_fail++; $display("FAIL b2b_arready[%0d] got %b want 1", k, arready_b); end
    end
    rready_b = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    rst = 1'b1; ld_en = 1'b0; ld_idx = '0; ld_data = '0;
    araddr_a = '0; arvalid_a = 1'b0; rready_a = 1'b0;
    araddr_b = '0; arvalid_b = 1'b0; rready_b = 1'b0;
    test_reset();
    test_latency();
    test_errors();
    test_stall();
    test_read_before_write();
    test_reset_in_delay();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
